// File: rtl/mono_ctrl_pkg.sv
// Shared types and constants for the monophonic note controller.
package mono_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOOKUP = 1'b1
   } ctrl_state_e;

   localparam logic [6:0] NOTE_RESET    = 7'd69;
   localparam int         DEPTH_DEFAULT = 8;

   // One glide step toward tgt_i: move by (tgt-cur)>>>shift, snap to the
   // target once the step rounds to zero so the approach always converges.
   function automatic logic [31:0] glide_next(input logic [31:0] cur_i,
                                              input logic [31:0] tgt_i,
                                              input logic [3:0]  shift_i);
      logic signed [32:0] diff;
      logic signed [32:0] step;
      diff = $signed({1'b0, tgt_i}) - $signed({1'b0, cur_i});
      step = diff >>> shift_i;
      if (step == 33'sd0) begin
         glide_next = tgt_i;
      end else begin
         glide_next = cur_i + step[31:0];
      end
   endfunction

endpackage

// File: rtl/mono_note_controller_if.sv
// Event channel from the MIDI decoder plus the note-table lookup channel.
interface mono_note_controller_if;

   logic        ev_valid;
   logic        ev_ready;
   logic        ev_on;
   logic [6:0]  ev_note;
   logic [6:0]  table_note;
   logic [31:0] table_freq;

   modport master (
      output ev_valid, ev_on, ev_note, table_freq,
      input  ev_ready, table_note
   );

   modport slave (
      input  ev_valid, ev_on, ev_note, table_freq,
      output ev_ready, table_note
   );

endinterface

// File: rtl/mono_note_controller_note_stack.sv
// Newest-first held-key stack: parallel match, push with dedupe,
// remove-and-compact. Exposes next-state count/top so the caller can
// register the new note on the same edge as the edit.
module note_stack
   import mono_ctrl_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEFAULT,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          edit_i,
   input  logic          on_i,
   input  logic [6:0]    note_i,
   output logic [CW-1:0] count_o,
   output logic [CW-1:0] count_d_o,
   output logic [6:0]    top_d_o
);

   logic [6:0]    stk_q [DEPTH];
   logic [6:0]    stk_d [DEPTH];
   logic [6:0]    ext_s [DEPTH+1];
   logic [6:0]    rem_s [DEPTH];
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic [CW-1:0] rem_cnt_s;
   logic          hit_s;

   // Remove any live copy of note_i; entries past the hit shift up one slot.
   always_comb begin
      hit_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ext_s[i] = stk_q[i];
      end
      ext_s[DEPTH] = 7'd0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_s = hit_s | ((i < int'(count_q)) && (stk_q[i] == note_i));
         if (hit_s) begin
            rem_s[i] = ext_s[i+1];
         end else begin
            rem_s[i] = ext_s[i];
         end
      end
      rem_cnt_s = count_q - {{(CW-1){1'b0}}, hit_s};
   end

   // Note-on pushes onto the compacted list (oldest falls off when full);
   // note-off keeps the compacted list as is.
   always_comb begin
      stk_d   = stk_q;
      count_d = count_q;
      if (edit_i && on_i) begin
         stk_d[0] = note_i;
         for (int i = 1; i < DEPTH; i++) begin
            stk_d[i] = rem_s[i-1];
         end
         if (rem_cnt_s == CW'(DEPTH)) begin
            count_d = CW'(DEPTH);
         end else begin
            count_d = rem_cnt_s + {{(CW-1){1'b0}}, 1'b1};
         end
      end else if (edit_i) begin
         stk_d   = rem_s;
         count_d = rem_cnt_s;
      end else begin
         stk_d   = stk_q;
         count_d = count_q;
      end
   end

   // Stack storage and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stk_q[i] <= 7'd0;
         end
         count_q <= {CW{1'b0}};
      end else begin
         stk_q   <= stk_d;
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign count_d_o = count_d;
   assign top_d_o   = stk_d[0];

endmodule

// File: rtl/mono_note_controller.sv
// Last-note-priority monophonic controller: key stack, note-table lookup
// sequencing, gate/trigger generation and exponential glide.
module mono_note_controller
   import mono_ctrl_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter bit RETRIG = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   mono_note_controller_if.slave        bus,
   input  logic                         glide_tick,
   input  logic [3:0]                   glide_shift,
   output logic [31:0]                  freq_out,
   output logic                         gate,
   output logic                         trig
);

   localparam int CW = $clog2(DEPTH + 1);

   ctrl_state_e   state_q, state_d;
   logic          pend_on_q, pend_on_d;
   logic          gate_q, gate_d;
   logic          trig_q, trig_d;
   logic [31:0]   freq_q, freq_d;
   logic [31:0]   target_q, target_d;
   logic [6:0]    note_q, note_d;
   logic          accept_s;
   logic          load_s;
   logic [CW-1:0] count_s;
   logic [CW-1:0] count_next_s;
   logic [6:0]    top_next_s;

   assign accept_s = bus.ev_valid && (state_q == ST_IDLE);

   note_stack #(.DEPTH(DEPTH)) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .edit_i    (accept_s),
      .on_i      (bus.ev_on),
      .note_i    (bus.ev_note),
      .count_o   (count_s),
      .count_d_o (count_next_s),
      .top_d_o   (top_next_s)
   );

   // Sequencing: accept an edit in IDLE, consume the table result in LOOKUP.
   always_comb begin
      state_d   = state_q;
      pend_on_d = pend_on_q;
      gate_d    = gate_q;
      trig_d    = 1'b0;
      target_d  = target_q;
      note_d    = note_q;
      load_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d   = ST_LOOKUP;
               pend_on_d = bus.ev_on;
               // An emptied stack keeps the last address so release rings on it.
               if (count_next_s != {CW{1'b0}}) begin
                  note_d = top_next_s;
               end else begin
                  note_d = note_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            state_d = ST_IDLE;
            if (count_s != {CW{1'b0}}) begin
               target_d = bus.table_freq;
               gate_d   = 1'b1;
               trig_d   = pend_on_q && (RETRIG || !gate_q);
               // No glide when starting from silence or with glide disabled.
               load_s   = !gate_q || (glide_shift == 4'd0);
            end else begin
               gate_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Frequency word: an immediate load wins over a glide step against the old target.
   always_comb begin
      freq_d = freq_q;
      if (load_s) begin
         freq_d = bus.table_freq;
      end else if (glide_tick) begin
         freq_d = glide_next(freq_q, target_q, glide_shift);
      end else begin
         freq_d = freq_q;
      end
   end

   // Controller state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pend_on_q <= 1'b0;
         gate_q    <= 1'b0;
         trig_q    <= 1'b0;
         freq_q    <= 32'd0;
         target_q  <= 32'd0;
         note_q    <= NOTE_RESET;
      end else begin
         state_q   <= state_d;
         pend_on_q <= pend_on_d;
         gate_q    <= gate_d;
         trig_q    <= trig_d;
         freq_q    <= freq_d;
         target_q  <= target_d;
         note_q    <= note_d;
      end
   end

   assign bus.ev_ready   = (state_q == ST_IDLE);
   assign bus.table_note = note_q;
   assign freq_out       = freq_q;
   assign gate           = gate_q;
   assign trig           = trig_q;

endmodule
